// File: rtl/sequential_unsigned_divider_if.sv
// Handshake bundle for the iterative unsigned divider.
// The master issues requests and the slave returns registered results.
interface sequential_unsigned_divider_if #(
  parameter int WIDTH = 8
) ();
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  overflow
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero,
    output overflow
  );
endinterface

// File: rtl/sequential_unsigned_divider.sv
// Restoring divider: 2W-bit dividend by W-bit divisor.
// Produces one quotient bit per clock behind start/busy/done.
module sequential_unsigned_divider #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  sequential_unsigned_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dsr_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_n;
  logic             dbz;
  logic             dbz_n;
  logic             ovf;
  logic             ovf_n;
  logic             done;
  logic             done_n;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign hi = bus.dividend[2*WIDTH-1:WIDTH];
  assign lo = bus.dividend[WIDTH-1:0];

  // R < divisor is invariant, so the trial remainder needs one extra bit only.
  assign t      = {r, q[WIDTH-1]};
  assign diff   = t - {1'b0, dsr};
  assign ge     = (t >= {1'b0, dsr});
  assign r_step = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_step = {q[WIDTH-2:0], ge};

  always_comb begin
    state_n = state;
    r_n     = r;
    q_n     = q;
    dsr_n   = dsr;
    cnt_n   = cnt;
    quo_n   = quo;
    rem_n   = rem;
    dbz_n   = dbz;
    ovf_n   = ovf;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          dbz_n = 1'b0;
          ovf_n = 1'b0;
          dsr_n = bus.divisor;
          r_n   = hi;
          q_n   = lo;
          cnt_n = '0;
          if (bus.divisor == '0) begin
            dbz_n  = 1'b1;
            quo_n  = '1;
            rem_n  = lo;
            done_n = 1'b1;
          end else if (hi >= bus.divisor) begin
            ovf_n  = 1'b1;
            quo_n  = '1;
            rem_n  = lo;
            done_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        r_n   = r_step;
        q_n   = q_step;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          quo_n   = q_step;
          rem_n   = r_step;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      q     <= '0;
      dsr   <= '0;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      r     <= r_n;
      q     <= q_n;
      dsr   <= dsr_n;
      cnt   <= cnt_n;
      quo   <= quo_n;
      rem   <= rem_n;
      dbz   <= dbz_n;
      ovf   <= ovf_n;
      done  <= done_n;
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = done;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign bus.overflow    = ovf;

endmodule

// File: doc/sequential_unsigned_divider.md
# sequential_unsigned_divider

Iterative restoring divider that inverts the unsigned multiplier: it divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor and returns a WIDTH-bit quotient and a WIDTH-bit remainder. It takes one quotient bit per clock behind a start/busy/done handshake. It sits in the arithmetic datapath beside the multiplier and accepts full-width products directly.

## Interface

- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2*WIDTH  unsigned dividend, sampled with start
- divisor  input  WIDTH  unsigned divisor, sampled with start
- busy  output  1  division in progress
- done  output  1  one-cycle completion pulse
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  divisor was 0 for the last accepted request
- overflow  output  1  quotient did not fit in WIDTH bits (divisor non-zero)

## Operation

- States: IDLE, RUN. No other states.
- IDLE + start=1 at edge N: clear div_by_zero/overflow, latch operands, check errors:
  - divisor==0: div_by_zero<=1, quotient<=all ones, remainder<=dividend[WIDTH-1:0], done<=1, stay IDLE.
  - else dividend[2W-1:W] >= divisor: overflow<=1, quotient<=all ones, remainder<=dividend[WIDTH-1:0], done<=1, stay IDLE.
  - else: R<=dividend[2W-1:W] (WIDTH bits), Q<=dividend[W-1:0], count<=0, go RUN.
- RUN, each edge (one iteration): T={R, Q[W-1]} (WIDTH+1 bits).
  - If T>=divisor: R<=T-divisor, shift 1 into Q LSB.
  - Else: R<=T[W-1:0], shift 0 into Q LSB.
  - count increments.
- Invariant R<divisor holds, so R always fits WIDTH bits.
- On the WIDTH-th iteration: quotient<=final Q, remainder<=final R, done<=1, go IDLE.
- start in RUN: ignored, no queuing.
- start in the cycle done=1: state is IDLE, so it is accepted normally.
- quotient/remainder/flags hold their values until the next completion. Flags clear on the next accepted start.
- Reset (any time, including mid-RUN): state IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0. The aborted operation never produces done.

## Timing

- Normal latency: start sampled at edge N. busy=1 after edges N..N+WIDTH-1. At edge N+WIDTH, results update, done=1 and busy=0 for exactly one cycle (the cycle after edge N+WIDTH).
- Error latency: done=1 and results valid in the cycle after edge N; busy never asserts.
- busy and done are never high together.
- Throughput: one division per WIDTH+1 cycles when start is held high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- WIDTH=8, dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0. busy for 8 cycles; done pulses 1 cycle after edge N+8.
- dividend=100, divisor=0 -> div_by_zero=1, overflow=0, quotient=0xFF, remainder=100. done in the cycle after the start edge; busy stays 0.
- dividend=0x0700, divisor=7 -> overflow=1, quotient=0xFF, remainder=0x00. Then dividend=0x06FF, divisor=7 -> overflow=0, quotient=255, remainder=6.
- dividend=0xFE01, divisor=255 -> quotient=255, remainder=0. dividend=0, divisor=1 -> quotient=0, remainder=0.
- Handshake: hold start=1 with new operands during RUN -> ignored, first result is unchanged. Start asserted in the done cycle -> accepted, and the second done arrives exactly 9 cycles after the first.
- Drop rst_n at cycle 4 of RUN -> all outputs 0 immediately, no done pulse. After release, a fresh 1000/7 request completes correctly.
